wbm_req_engine: RTL and testbench

//  Wishbone classic-cycle initiator: drives single read/write transactions onto a

---
 rtl/wbm_req_engine.sv | 159 +++++++++++++++
 tb/tb_wbm_req_engine.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wbm_req_engine.sv
// -----------------------------------------------------------------------------
// wbm_req_engine
//   Wishbone classic-cycle initiator. Takes one read or write request from a
//   valid/ready request channel, runs it as a single cyc/stb transfer on the
//   Wishbone master port, and returns read data plus error/timeout status on a
//   valid/ready response channel. At most one transaction is outstanding.
//
// Parameters
//   AW          address width
//   DW          data width (byte-select width is DW/8)
//   TIMEOUT_CYC cycles cyc/stb may be held without ack/err before abort (>=1)
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_we/req_adr/req_dat/req_sel  request payload
//   rsp_valid/rsp_ready             response handshake
//   rsp_dat/rsp_err/rsp_tmo         response payload (tmo implies err)
//   wbm_cyc_o..wbm_dat_o            Wishbone master outputs (all registered)
//   wbm_dat_i/wbm_ack_i/wbm_err_i   Wishbone slave returns
// -----------------------------------------------------------------------------
module wbm_req_engine #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  // request channel
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_adr,
  input  logic [DW-1:0]   req_dat,
  input  logic [DW/8-1:0] req_sel,
  // response channel
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_dat,
  output logic            rsp_err,
  output logic            rsp_tmo,
  // Wishbone master port
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic [DW-1:0]   wbm_dat_o,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic            wbm_ack_i,
  input  logic            wbm_err_i
);

  localparam int SW = DW / 8;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            cyc_q, stb_q, we_q;
  logic [AW-1:0]   adr_q;
  logic [SW-1:0]   sel_q;
  logic [DW-1:0]   dat_o_q;
  logic            rsp_valid_q, rsp_err_q, rsp_tmo_q;
  logic [DW-1:0]   rsp_dat_q;

  // Ready is decoded from state and gated by rst_n so no request can be
  // accepted (or appear accepted) while reset is held.
  assign req_ready = (state_q == ST_IDLE) && rst_n;

  // NOTE: every register here is updated with <= so all state advances
  // together on the edge; blocking assignments would let later statements see
  // half-updated values and break the one-cycle handshake timing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      sel_q       <= '0;
      dat_o_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
      rsp_dat_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            adr_q   <= req_adr;
            sel_q   <= req_sel;
            dat_o_q <= req_dat;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_BUS;
          end
        end

        ST_BUS: begin
          if (wbm_err_i || wbm_ack_i) begin
            // err wins over a simultaneous ack; reads return data only on a
            // clean ack.
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= wbm_err_i;
            rsp_tmo_q   <= 1'b0;
            rsp_dat_q   <= (!wbm_err_i && !we_q) ? wbm_dat_i : '0;
            state_q     <= ST_RESP;
          end else if (cnt_q == CNT_LAST) begin
            // This is the TIMEOUT_CYC-th cycle without a reply: abort.
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_tmo_q   <= 1'b1;
            rsp_dat_q   <= '0;
            state_q     <= ST_RESP;
          end else begin
            // Only counts below CNT_LAST, so it saturates and never wraps.
            cnt_q <= cnt_q + CW'(1);
          end
        end

        ST_RESP: begin
          // Late ack/err are ignored here since the bus is idle.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_sel_o = sel_q;
  assign wbm_dat_o = dat_o_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_tmo   = rsp_tmo_q;
  assign rsp_dat   = rsp_dat_q;

endmodule

// File: tb/tb_wbm_req_engine.sv
// -----------------------------------------------------------------------------
// tb_wbm_req_engine
//   Directed bench for wbm_req_engine with TIMEOUT_CYC=8. Each scenario task
//   drives the request channel and plays the Wishbone slave by hand, then
//   compares outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_wbm_req_engine;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_adr;
  logic [DW-1:0] req_dat;
  logic [3:0]    req_sel;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_tmo;
  logic [DW-1:0] rsp_dat;
  logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [AW-1:0] wbm_adr_o;
  logic [3:0]    wbm_sel_o;
  logic [DW-1:0] wbm_dat_o, wbm_dat_i;
  logic          wbm_ack_i, wbm_err_i;

  int passed = 0;
  int total  = 0;

  wbm_req_engine #(.AW(AW), .DW(DW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_dat(req_dat), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_err(rsp_err), .rsp_tmo(rsp_tmo),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_adr_o(wbm_adr_o), .wbm_sel_o(wbm_sel_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [AW-1:0] adr,
                           input logic [DW-1:0] dat, input logic [3:0] sel);
    req_valid = 1'b1;
    req_we    = we;
    req_adr   = adr;
    req_dat   = dat;
    req_sel   = sel;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total++; if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0)
      $display("FAIL reset_cyc_stb: cyc=%b stb=%b want 0 0", wbm_cyc_o, wbm_stb_o); else passed++;
    total++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_tmo !== 1'b0)
      $display("FAIL reset_rsp: valid=%b err=%b tmo=%b want 0 0 0", rsp_valid, rsp_err, rsp_tmo); else passed++;
    total++; if (wbm_adr_o !== '0 || wbm_dat_o !== '0 || wbm_sel_o !== '0 || rsp_dat !== '0)
      $display("FAIL reset_data: adr=%h dat=%h sel=%h rdat=%h want 0", wbm_adr_o, wbm_dat_o, wbm_sel_o, rsp_dat); else passed++;
    total++; if (req_ready !== 1'b0)
      $display("FAIL reset_ready_low: got %b want 0", req_ready); else passed++;
    rst_n = 1'b1;
    #1;
    total++; if (req_ready !== 1'b1)
      $display("FAIL reset_ready_idle: got %b want 1", req_ready); else passed++;
  endtask

  task automatic test_write();
    int cyc_cycles = 0;
    drive_req(1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF);
    tick();
    req_valid = 1'b0;
    total++; if (wbm_cyc_o !== 1'b1 || wbm_stb_o !== 1'b1 || wbm_we_o !== 1'b1 || req_ready !== 1'b0)
      $display("FAIL wr_bus_start: cyc=%b stb=%b we=%b rdy=%b want 1 1 1 0", wbm_cyc_o, wbm_stb_o, wbm_we_o, req_ready); else passed++;
    total++; if (wbm_adr_o !== 32'h3000_0010 || wbm_dat_o !== 32'hDEAD_BEEF || wbm_sel_o !== 4'hF)
      $display("FAIL wr_bus_fields: adr=%h dat=%h sel=%h want 30000010 deadbeef f", wbm_adr_o, wbm_dat_o, wbm_sel_o); else passed++;
    for (int i = 0; i < 3; i++) begin
      if (wbm_cyc_o && wbm_stb_o) cyc_cycles++;
      wbm_ack_i = (i == 2);
      tick();
    end
    wbm_ack_i = 1'b0;
    total++; if (cyc_cycles !== 3 || wbm_cyc_o !== 1'b0)
      $display("FAIL wr_cyc_len: cycles=%0d cyc=%b want 3 0", cyc_cycles, wbm_cyc_o); else passed++;
    total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_tmo !== 1'b0 || rsp_dat !== '0)
      $display("FAIL wr_rsp: valid=%b err=%b tmo=%b dat=%h want 1 0 0 0", rsp_valid, rsp_err, rsp_tmo, rsp_dat); else passed++;
    consume();
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL wr_done: valid=%b rdy=%b want 0 1", rsp_valid, req_ready); else passed++;
  endtask

  task automatic test_read();
    drive_req(1'b0, 32'h3000_0004, 32'h0, 4'hF);
    tick();
    req_valid = 1'b0;
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h1234_5678;
    total++; if (wbm_cyc_o !== 1'b1 || wbm_we_o !== 1'b0 || wbm_adr_o !== 32'h3000_0004 || rsp_valid !== 1'b0)
      $display("FAIL rd_bus: cyc=%b we=%b adr=%h rvalid=%b want 1 0 30000004 0", wbm_cyc_o, wbm_we_o, wbm_adr_o, rsp_valid); else passed++;
    tick();
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'hFFFF_0000;
    #1;
    total++; if (rsp_valid !== 1'b1 || rsp_dat !== 32'h1234_5678 || rsp_err !== 1'b0 || wbm_cyc_o !== 1'b0)
      $display("FAIL rd_rsp: valid=%b dat=%h err=%b cyc=%b want 1 12345678 0 0", rsp_valid, rsp_dat, rsp_err, wbm_cyc_o); else passed++;
    consume();
    wbm_dat_i = '0;
  endtask

  task automatic test_error();
    drive_req(1'b0, 32'h3000_0008, 32'h0, 4'h3);
    tick();
    req_valid = 1'b0;
    wbm_ack_i = 1'b1;
    wbm_err_i = 1'b1;
    wbm_dat_i = 32'hCAFE_F00D;
    tick();
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_dat_i = '0;
    total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_tmo !== 1'b0 || rsp_dat !== '0)
      $display("FAIL err_rsp: valid=%b err=%b tmo=%b dat=%h want 1 1 0 0", rsp_valid, rsp_err, rsp_tmo, rsp_dat); else passed++;
    total++; if (wbm_sel_o !== 4'h3 || wbm_cyc_o !== 1'b0)
      $display("FAIL err_bus: sel=%h cyc=%b want 3 0", wbm_sel_o, wbm_cyc_o); else passed++;
    consume();
  endtask

  task automatic test_timeout();
    int cyc_cycles = 0;
    drive_req(1'b0, 32'h3000_0040, 32'h0, 4'hF);
    wbm_dat_i = 32'h5555_AAAA;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!wbm_cyc_o) break;
      cyc_cycles++;
      tick();
    end
    total++; if (cyc_cycles !== TMO || wbm_stb_o !== 1'b0)
      $display("FAIL tmo_len: cycles=%0d stb=%b want %0d 0", cyc_cycles, wbm_stb_o, TMO); else passed++;
    total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_tmo !== 1'b1 || rsp_dat !== '0)
      $display("FAIL tmo_rsp: valid=%b err=%b tmo=%b dat=%h want 1 1 1 0", rsp_valid, rsp_err, rsp_tmo, rsp_dat); else passed++;
    // Late ack while the response is still waiting must change nothing.
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    wbm_dat_i = '0;
    total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_tmo !== 1'b1 || rsp_dat !== '0 || wbm_cyc_o !== 1'b0)
      $display("FAIL tmo_late_ack: valid=%b err=%b tmo=%b dat=%h cyc=%b want 1 1 1 0 0", rsp_valid, rsp_err, rsp_tmo, rsp_dat, wbm_cyc_o); else passed++;
    consume();
    tick();
    total++; if (wbm_cyc_o !== 1'b0 || rsp_valid !== 1'b0)
      $display("FAIL tmo_idle_after: cyc=%b valid=%b want 0 0", wbm_cyc_o, rsp_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    drive_req(1'b0, 32'h3000_0100, 32'h0, 4'hF);
    tick();
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'hA5A5_0001;
    // Next request is already pending while the first one finishes.
    drive_req(1'b1, 32'h3000_0200, 32'h0BAD_F00D, 4'hC);
    tick();
    wbm_ack_i = 1'b0;
    wbm_dat_i = '0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_dat !== 32'hA5A5_0001 || req_ready !== 1'b0 || wbm_cyc_o !== 1'b0) bad++;
      tick();
    end
    total++; if (bad !== 0)
      $display("FAIL bp_hold: bad_cycles=%0d want 0 (valid=%b dat=%h rdy=%b)", bad, rsp_valid, rsp_dat, req_ready); else passed++;
    consume();
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || wbm_cyc_o !== 1'b0)
      $display("FAIL bp_release: valid=%b rdy=%b cyc=%b want 0 1 0", rsp_valid, req_ready, wbm_cyc_o); else passed++;
    tick();
    req_valid = 1'b0;
    total++; if (wbm_cyc_o !== 1'b1 || wbm_we_o !== 1'b1 || wbm_adr_o !== 32'h3000_0200 || wbm_dat_o !== 32'h0BAD_F00D || wbm_sel_o !== 4'hC)
      $display("FAIL bp_next_req: cyc=%b we=%b adr=%h dat=%h sel=%h want 1 1 30000200 0badf00d c", wbm_cyc_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o); else passed++;
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== '0)
      $display("FAIL bp_next_rsp: valid=%b err=%b dat=%h want 1 0 0", rsp_valid, rsp_err, rsp_dat); else passed++;
    consume();
  endtask

  task automatic test_reset_mid_bus();
    int seen = 0;
    drive_req(1'b1, 32'h3000_0300, 32'h1111_2222, 4'hF);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    total++; if (wbm_cyc_o !== 1'b1)
      $display("FAIL rst_mid_pre: cyc=%b want 1", wbm_cyc_o); else passed++;
    rst_n = 1'b0;
    tick();
    total++; if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || rsp_valid !== 1'b0)
      $display("FAIL rst_mid_drop: cyc=%b stb=%b valid=%b want 0 0 0", wbm_cyc_o, wbm_stb_o, rsp_valid); else passed++;
    rst_n = 1'b1;
    wbm_ack_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      wbm_ack_i = 1'b0;
      if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0) seen++;
    end
    total++; if (seen !== 0 || req_ready !== 1'b1)
      $display("FAIL rst_mid_after: bad_cycles=%0d rdy=%b want 0 1", seen, req_ready); else passed++;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_adr   = '0;
    req_dat   = '0;
    req_sel   = '0;
    rsp_ready = 1'b0;
    wbm_dat_i = '0;
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    #1;
    test_reset();
    test_write();
    test_read();
    test_error();
    test_timeout();
    test_back_to_back();
    test_reset_mid_bus();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
